// File: rtl/rf_writeback_ctrl_if.sv
// Groups the issue, ALU, MDU and register-file write buses of the writeback controller.
// Carries no state. Latency is set by the controller.
// Only the MDU result can be back-pressured, through o_mdu_ready. The ALU result cannot.
interface rf_writeback_ctrl_if #(
  parameter int NUM_REGISTER = 32,
  parameter int DATA_WIDTH   = 32
);
  localparam int AW = $clog2(NUM_REGISTER);

  // issue-side hazard query
  logic                  i_issue_valid;
  logic                  i_issue_long;
  logic [AW-1:0]         i_issue_rd_addr;
  logic [AW-1:0]         i_issue_rs1_addr;
  logic [AW-1:0]         i_issue_rs2_addr;
  logic                  i_issue_uses_rs1;
  logic                  i_issue_uses_rs2;
  logic                  o_issue_stall;

  // single-cycle ALU result, never back-pressured
  logic                  i_alu_valid;
  logic [AW-1:0]         i_alu_rd_addr;
  logic [DATA_WIDTH-1:0] i_alu_data;

  // multi-cycle MDU result, valid/ready handshake
  logic                  i_mdu_valid;
  logic [AW-1:0]         i_mdu_rd_addr;
  logic [DATA_WIDTH-1:0] i_mdu_data;
  logic                  o_mdu_ready;

  // register file write port
  logic                  o_we;
  logic [AW-1:0]         o_rd_addr;
  logic [DATA_WIDTH-1:0] o_rd;

  modport master (
    output i_issue_valid, i_issue_long, i_issue_rd_addr, i_issue_rs1_addr,
           i_issue_rs2_addr, i_issue_uses_rs1, i_issue_uses_rs2,
           i_alu_valid, i_alu_rd_addr, i_alu_data,
           i_mdu_valid, i_mdu_rd_addr, i_mdu_data,
    input  o_issue_stall, o_mdu_ready, o_we, o_rd_addr, o_rd
  );

  modport slave (
    input  i_issue_valid, i_issue_long, i_issue_rd_addr, i_issue_rs1_addr,
           i_issue_rs2_addr, i_issue_uses_rs1, i_issue_uses_rs2,
           i_alu_valid, i_alu_rd_addr, i_alu_data,
           i_mdu_valid, i_mdu_rd_addr, i_mdu_data,
    output o_issue_stall, o_mdu_ready, o_we, o_rd_addr, o_rd
  );
endinterface

// File: rtl/rf_writeback_ctrl.sv
// Merges ALU and MDU results onto the single register-file write port and scoreboards MDU destinations.
// Latency: a write reaches the port 1 cycle after it wins arbitration. Stall and ready are combinational.
// Backpressure: the ALU always wins. The MDU waits on o_mdu_ready. Issue stalls on hazards, when full, or when the MDU is starved.
module rf_writeback_ctrl #(
  parameter int NUM_REGISTER    = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  rf_writeback_ctrl_if.slave  bus
);
  localparam int AW = $clog2(NUM_REGISTER);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [NUM_REGISTER-1:0] pending_q, pending_d;
  logic [CW-1:0]           count_q;
  logic [SW-1:0]           starve_q;
  logic                    we_q;
  logic [AW-1:0]           wr_addr_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;

  logic mdu_ready, mdu_hs;
  logic rs1_hazard, rs2_hazard, waw_hazard, full, starved;
  logic stall, long_accept;

  // Hazard detection and arbitration. Only registered state is used, so an MDU result
  // retiring this cycle does not release the stall until the following cycles.
  always_comb begin
    mdu_ready   = i_rst_n & ~bus.i_alu_valid;
    mdu_hs      = bus.i_mdu_valid & mdu_ready;
    rs1_hazard  = bus.i_issue_uses_rs1 && (bus.i_issue_rs1_addr != '0) &&
                  (pending_q[bus.i_issue_rs1_addr] || (we_q && (wr_addr_q == bus.i_issue_rs1_addr)));
    rs2_hazard  = bus.i_issue_uses_rs2 && (bus.i_issue_rs2_addr != '0) &&
                  (pending_q[bus.i_issue_rs2_addr] || (we_q && (wr_addr_q == bus.i_issue_rs2_addr)));
    waw_hazard  = bus.i_issue_long && (bus.i_issue_rd_addr != '0) && pending_q[bus.i_issue_rd_addr];
    full        = bus.i_issue_long && (count_q == CW'(MAX_OUTSTANDING));
    starved     = (starve_q >= SW'(STARVE_LIMIT));
    stall       = bus.i_issue_valid & (rs1_hazard | rs2_hazard | waw_hazard | full | starved);
    long_accept = bus.i_issue_valid & ~stall & bus.i_issue_long;
  end

  // Next pending bitmap. The retiring destination is cleared before the newly issued one is set.
  always_comb begin
    pending_d = pending_q;
    if (mdu_hs) pending_d[bus.i_mdu_rd_addr] = 1'b0;
    if (long_accept && (bus.i_issue_rd_addr != '0)) pending_d[bus.i_issue_rd_addr] = 1'b1;
  end

  // Register-file write port. The ALU beats the MDU, and a write to x0 is never driven.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (bus.i_alu_valid) begin
      we_q      <= (bus.i_alu_rd_addr != '0);
      wr_addr_q <= bus.i_alu_rd_addr;
      wr_data_q <= bus.i_alu_data;
    end else if (mdu_hs) begin
      we_q      <= (bus.i_mdu_rd_addr != '0);
      wr_addr_q <= bus.i_mdu_rd_addr;
      wr_data_q <= bus.i_mdu_data;
    end else begin
      we_q      <= 1'b0;
    end
  end

  // Scoreboard of MDU destinations still in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) pending_q <= '0;
    else          pending_q <= pending_d;
  end

  // In-flight MDU op count. A handshake seen at zero is ignored rather than wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      if (long_accept && !(mdu_hs && (count_q != '0)))
        count_q <= count_q + CW'(1);
      else if (!long_accept && mdu_hs && (count_q != '0))
        count_q <= count_q - CW'(1);
    end
  end

  // Counts cycles an offered MDU result loses to the ALU. It saturates and clears when the result is taken or withdrawn.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_q <= '0;
    end else if (!bus.i_mdu_valid || mdu_hs) begin
      starve_q <= '0;
    end else if (bus.i_alu_valid && (starve_q < SW'(STARVE_LIMIT))) begin
      starve_q <= starve_q + SW'(1);
    end
  end

  assign bus.o_issue_stall = stall;
  assign bus.o_mdu_ready   = mdu_ready;
  assign bus.o_we          = we_q;
  assign bus.o_rd_addr     = wr_addr_q;
  assign bus.o_rd          = wr_data_q;
endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed bench for rf_writeback_ctrl. An abstract model is compared against the DUT on every falling edge.
// Literal checks are made 3 time units after each rising edge.
// Stimulus is driven 1 time unit after each rising edge.
module tb_rf_writeback_ctrl;
  localparam int NREG = 32;
  localparam int MAXO = 4;
  localparam int STRV = 8;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  rf_writeback_ctrl_if #(.NUM_REGISTER(NREG), .DATA_WIDTH(32)) bus ();

  rf_writeback_ctrl #(.NUM_REGISTER(NREG), .DATA_WIDTH(32),
                      .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(STRV)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_pend [NREG];
  int          m_cnt;
  int          m_starve;
  bit          m_we;
  int          m_addr;
  logic [31:0] m_dat;

  function automatic bit src_busy(input bit used, input int r);
    return used && (r != 0) && (m_pend[r] || (m_we && (m_addr == r)));
  endfunction

  function automatic bit model_stall();
    if (!bus.i_issue_valid) return 1'b0;
    if (src_busy(bus.i_issue_uses_rs1, int'(bus.i_issue_rs1_addr))) return 1'b1;
    if (src_busy(bus.i_issue_uses_rs2, int'(bus.i_issue_rs2_addr))) return 1'b1;
    if (bus.i_issue_long && (bus.i_issue_rd_addr != 0) && m_pend[bus.i_issue_rd_addr]) return 1'b1;
    if (bus.i_issue_long && (m_cnt == MAXO)) return 1'b1;
    if (m_starve >= STRV) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_cnt = 0; m_starve = 0; m_we = 1'b0; m_addr = 0; m_dat = '0;
    end else begin
      bit st, hs, acc;
      st  = model_stall();
      hs  = bus.i_mdu_valid && !bus.i_alu_valid;
      acc = bus.i_issue_valid && !st;
      if (bus.i_alu_valid) begin
        m_we = (bus.i_alu_rd_addr != 0); m_addr = int'(bus.i_alu_rd_addr); m_dat = bus.i_alu_data;
      end else if (hs) begin
        m_we = (bus.i_mdu_rd_addr != 0); m_addr = int'(bus.i_mdu_rd_addr); m_dat = bus.i_mdu_data;
      end else begin
        m_we = 1'b0;
      end
      if (hs) m_pend[bus.i_mdu_rd_addr] = 1'b0;
      if (acc && bus.i_issue_long && (bus.i_issue_rd_addr != 0)) m_pend[bus.i_issue_rd_addr] = 1'b1;
      if (hs && (m_cnt > 0)) m_cnt = m_cnt - 1;
      if (acc && bus.i_issue_long) m_cnt = m_cnt + 1;
      if (!bus.i_mdu_valid || hs) m_starve = 0;
      else if (bus.i_alu_valid && (m_starve < STRV)) m_starve = m_starve + 1;
    end
  end

  // compare process
  always @(negedge clk) begin
    chk("cmp_stall", 32'(bus.o_issue_stall), rst_n ? 32'(model_stall()) : 32'd0);
    chk("cmp_ready", 32'(bus.o_mdu_ready), rst_n ? 32'(!bus.i_alu_valid) : 32'd0);
    chk("cmp_we", 32'(bus.o_we), 32'(m_we));
    if (m_we) begin
      chk("cmp_addr", 32'(bus.o_rd_addr), m_addr[31:0]);
      chk("cmp_data", bus.o_rd, m_dat);
    end
    if (m_cnt > MAXO) chk("cmp_cnt_bound", m_cnt[31:0], MAXO);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_issue_valid = 0; bus.i_issue_long = 0; bus.i_issue_rd_addr = '0;
    bus.i_issue_rs1_addr = '0; bus.i_issue_rs2_addr = '0;
    bus.i_issue_uses_rs1 = 0; bus.i_issue_uses_rs2 = 0;
    bus.i_alu_valid = 0; bus.i_alu_rd_addr = '0; bus.i_alu_data = '0;
    bus.i_mdu_valid = 0; bus.i_mdu_rd_addr = '0; bus.i_mdu_data = '0;
  endtask

  task automatic alu(input int rd, input logic [31:0] d);
    bus.i_alu_valid = 1; bus.i_alu_rd_addr = 5'(rd); bus.i_alu_data = d;
  endtask

  task automatic mdu(input int rd, input logic [31:0] d);
    bus.i_mdu_valid = 1; bus.i_mdu_rd_addr = 5'(rd); bus.i_mdu_data = d;
  endtask

  task automatic issue(input bit lng, input int rd, input bit u1, input int rs1);
    bus.i_issue_valid = 1; bus.i_issue_long = lng; bus.i_issue_rd_addr = 5'(rd);
    bus.i_issue_uses_rs1 = u1; bus.i_issue_rs1_addr = 5'(rs1);
    bus.i_issue_uses_rs2 = 0; bus.i_issue_rs2_addr = '0;
  endtask

  task automatic starve_fill();
    step();
    alu(12, 32'h0000AAAA); mdu(13, 32'h0000BBBB); issue(0, 14, 0, 0);
    for (int i = 0; i <= STRV; i++) begin
      #2;
      chk("starve_ramp", 32'(bus.o_issue_stall), (i == STRV) ? 32'd1 : 32'd0);
      if (i < STRV) step();
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_we", 32'(bus.o_we), 0);
    chk("rst_stall", 32'(bus.o_issue_stall), 0);
    chk("rst_ready", 32'(bus.o_mdu_ready), 0);
    step(); rst_n = 1'b1;

    // ALU write, one-cycle latency
    step(); alu(1, 32'hDEADBEEF);
    step(); bus.i_alu_valid = 0; #2;
    chk("alu_we", 32'(bus.o_we), 1);
    chk("alu_addr", 32'(bus.o_rd_addr), 1);
    chk("alu_data", bus.o_rd, 32'hDEADBEEF);
    step(); #2;
    chk("alu_we_drop", 32'(bus.o_we), 0);

    // ALU/MDU collision
    step(); alu(2, 32'h12345678); mdu(3, 32'hCAFEF00D); #2;
    chk("col_ready", 32'(bus.o_mdu_ready), 0);
    step(); bus.i_alu_valid = 0; #2;
    chk("col_alu_addr", 32'(bus.o_rd_addr), 2);
    chk("col_alu_data", bus.o_rd, 32'h12345678);
    chk("col_ready2", 32'(bus.o_mdu_ready), 1);
    step(); bus.i_mdu_valid = 0; #2;
    chk("col_mdu_we", 32'(bus.o_we), 1);
    chk("col_mdu_addr", 32'(bus.o_rd_addr), 3);
    chk("col_mdu_data", bus.o_rd, 32'hCAFEF00D);
    step();

    // RAW on a pending MDU destination
    step(); issue(1, 5, 0, 0); #2;
    chk("raw_issue", 32'(bus.o_issue_stall), 0);
    step(); issue(0, 10, 1, 5); #2;
    chk("raw_stall", 32'(bus.o_issue_stall), 1);
    bus.i_issue_rs1_addr = '0; #1;
    chk("raw_x0", 32'(bus.o_issue_stall), 0);
    bus.i_issue_rs1_addr = 5'd5;
    step(); #2;
    chk("raw_hold", 32'(bus.o_issue_stall), 1);
    step(); mdu(5, 32'h00000055); #2;
    chk("raw_hs_cycle", 32'(bus.o_issue_stall), 1);
    step(); bus.i_mdu_valid = 0; #2;
    chk("raw_inflight", 32'(bus.o_issue_stall), 1);
    chk("raw_inflight_addr", 32'(bus.o_rd_addr), 5);
    step(); #2;
    chk("raw_release", 32'(bus.o_issue_stall), 0);
    step(); idle();

    // outstanding-count overflow
    for (int i = 0; i < MAXO; i++) begin
      step(); issue(1, 6 + i, 0, 0); #2;
      chk("ovf_fill", 32'(bus.o_issue_stall), 0);
    end
    step(); issue(1, 11, 0, 0); #2;
    chk("ovf_full", 32'(bus.o_issue_stall), 1);
    step(); mdu(6, 32'h00000066); #2;
    chk("ovf_hs_cycle", 32'(bus.o_issue_stall), 1);
    step(); bus.i_mdu_valid = 0; #2;
    chk("ovf_accept", 32'(bus.o_issue_stall), 0);
    step(); issue(1, 12, 0, 0); #2;
    chk("ovf_full_again", 32'(bus.o_issue_stall), 1);
    for (int i = 0; i < 4; i++) begin
      step(); idle(); mdu((i == 3) ? 11 : 7 + i, 32'h100 + i);
    end
    step(); idle();

    // x0 handling
    for (int i = 0; i < MAXO; i++) begin
      step(); issue(1, 0, 0, 0); #2;
      chk("x0_fill", 32'(bus.o_issue_stall), 0);
    end
    step(); #2;
    chk("x0_full", 32'(bus.o_issue_stall), 1);
    step(); mdu(0, 32'hFFFFFFFF); #2;
    chk("x0_ready", 32'(bus.o_mdu_ready), 1);
    step(); bus.i_mdu_valid = 0; #2;
    chk("x0_no_we", 32'(bus.o_we), 0);
    chk("x0_count_dec", 32'(bus.o_issue_stall), 0);
    step(); idle();
    for (int i = 0; i < MAXO; i++) begin
      step(); mdu(0, 32'h0);
    end
    step(); idle(); alu(0, 32'h00000001);
    step(); idle(); #2;
    chk("x0_alu_no_we", 32'(bus.o_we), 0);

    // starvation, then async reset mid-stall
    starve_fill();
    step(); #2;
    chk("starve_hold", 32'(bus.o_issue_stall), 1);
    rst_n = 1'b0; #1;
    chk("arst_we", 32'(bus.o_we), 0);
    chk("arst_stall", 32'(bus.o_issue_stall), 0);
    chk("arst_ready", 32'(bus.o_mdu_ready), 0);
    idle();
    step(); step(); rst_n = 1'b1;
    step(); #2;
    chk("post_rst_we", 32'(bus.o_we), 0);
    step(); #2;
    chk("post_rst_we2", 32'(bus.o_we), 0);

    // starvation released by the MDU handshake
    starve_fill();
    step(); bus.i_alu_valid = 0; #2;
    chk("starve_hs_ready", 32'(bus.o_mdu_ready), 1);
    chk("starve_hs_stall", 32'(bus.o_issue_stall), 1);
    step(); bus.i_mdu_valid = 0; #2;
    chk("starve_release", 32'(bus.o_issue_stall), 0);
    chk("starve_mdu_addr", 32'(bus.o_rd_addr), 13);
    chk("starve_mdu_data", bus.o_rd, 32'h0000BBBB);
    step(); idle();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rf_writeback_ctrl.md
Name: rf_writeback_ctrl

Overview:
- Write-side client of the RV32IM register file; owns its single write port (i_we/i_rd_addr/i_rd).
- Merges single-cycle ALU results and multi-cycle MUL/DIV (MDU) results onto that port.
- Tracks outstanding long-latency destinations in a scoreboard; stalls issue on RAW/WAW hazards and on outstanding-count overflow.

Parameters:
- NUM_REGISTER, 32, number of architectural registers; address width = $clog2(NUM_REGISTER).
- DATA_WIDTH, 32, register data width.
- MAX_OUTSTANDING, 4, maximum MDU ops in flight.
- STARVE_LIMIT, 8, consecutive cycles an MDU result may be refused before issue is forced to stall.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_issue_valid  input  1  instruction presented at issue.
- i_issue_long  input  1  instruction is an MDU op.
- i_issue_rd_addr  input  AW  destination register.
- i_issue_rs1_addr  input  AW  source register 1.
- i_issue_rs2_addr  input  AW  source register 2.
- i_issue_uses_rs1  input  1  rs1 is read.
- i_issue_uses_rs2  input  1  rs2 is read.
- o_issue_stall  output  1  issue must hold; combinational.
- i_alu_valid  input  1  ALU result this cycle; cannot be back-pressured.
- i_alu_rd_addr  input  AW  ALU destination.
- i_alu_data  input  DATA_WIDTH  ALU result.
- i_mdu_valid  input  1  MDU result offered.
- i_mdu_rd_addr  input  AW  MDU destination.
- i_mdu_data  input  DATA_WIDTH  MDU result.
- o_mdu_ready  output  1  MDU result accepted this cycle; combinational.
- o_we  output  1  register file write enable.
- o_rd_addr  output  AW  register file write address.
- o_rd  output  DATA_WIDTH  register file write data.

Behaviour:
- Reset (async, i_rst_n=0):
  - o_we=0, o_rd_addr=0, o_rd=0.
  - Pending bitmap all 0; outstanding count 0; starve counter 0.
  - Combinational outputs go low as a result (o_issue_stall=0, o_mdu_ready=0 with i_alu_valid=0).
  - Reset mid-operation discards in-flight writes and pending state; no write occurs on the cycle reset deasserts.
- Write port, registered, 1-cycle latency: o_we/o_rd_addr/o_rd update every rising edge from the arbitration winner. o_we=0 when there is no winner.
- Arbitration:
  - ALU has absolute priority: o_mdu_ready = ~i_alu_valid.
  - MDU handshake = i_mdu_valid & o_mdu_ready.
  - Writes to x0 never assert o_we. An ALU result to x0 is dropped. An MDU result to x0 is still accepted (handshake and count decrement happen, no write).
- Scoreboard:
  - Pending bit set on an accepted issue (i_issue_valid & ~o_issue_stall) with i_issue_long=1 and rd≠0.
  - Pending bit cleared on an MDU handshake for that rd.
  - Updates are registered; the stall decision uses only current registered state, with no same-cycle bypass.
- Outstanding count:
  - +1 on every accepted long issue, including rd=0.
  - −1 on every MDU handshake.
  - Simultaneous +1/−1 leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING; never underflows. An MDU handshake at count 0 is a protocol error; the count holds at 0.
- o_issue_stall=1 when i_issue_valid and any of:
  - a used rs has its pending bit set;
  - a used rs ≠ 0 equals o_rd_addr while o_we=1 (write in flight, not yet visible in the register file);
  - i_issue_long and rd≠0 and rd is pending (WAW);
  - i_issue_long and count==MAX_OUTSTANDING;
  - starve counter ≥ STARVE_LIMIT.
- Starve counter:
  - Increments each cycle i_mdu_valid & i_alu_valid; saturates at STARVE_LIMIT.
  - Clears on MDU handshake or when ~i_mdu_valid.
  - Stall from starvation holds until the MDU result is accepted.
- x0 as a source never causes a stall.

Test Plan:
- Reset then ALU write: i_alu_valid=1, rd=1, data=32'hDEADBEEF for one cycle -> next cycle o_we=1, o_rd_addr=1, o_rd=DEADBEEF; following cycle o_we=0.
- Collision: ALU (rd=2, 32'h12345678) and MDU (rd=3, 32'hCAFEF00D) valid in the same cycle -> o_mdu_ready=0, ALU written first; MDU written the cycle after ALU valid drops.
- RAW stall: long issue rd=5, then issue with rs1=5 -> o_issue_stall=1 until MDU rd=5 handshake plus one cycle (write-in-flight window); rs1=0 never stalls.
- Overflow: four long issues rd=6..9 accepted, fifth long issue -> stalled; one MDU handshake -> fifth accepted the next cycle; count stays ≤4.
- x0: MDU result rd=0, data=32'hFFFFFFFF -> o_mdu_ready=1, o_we stays 0, count decrements; ALU rd=0 -> no write.
- Starvation and reset: i_alu_valid held high with MDU valid for 8 cycles -> o_issue_stall=1; async reset pulse mid-stall -> all outputs and counters 0 immediately, no spurious write after release.
